// File: rtl/ysyx_23060191_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave):
// a valid/ready request channel and a valid-only response channel.
interface ysyx_23060191_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060191_lsu.sv
// Load/store unit: one aligned word transaction per instruction, IDLE->REQ->WAIT->DONE.
// Optional LSU_MISALIGN_CHECK_EN adds lsu_err and short-circuits misaligned half/word ops.
module ysyx_23060191_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            lsu_op,
    input  logic [DATA_WIDTH-1:0] exu_res,
    input  logic [DATA_WIDTH-1:0] data_Rs2,
    ysyx_23060191_lsu_if.master   bus,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic                  lsu_err,
`endif
    output logic [DATA_WIDTH-1:0] lsu_res
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [3:0] OP_LB  = 4'h1, OP_LH  = 4'h2, OP_LW = 4'h3,
                           OP_LBU = 4'h4, OP_LHU = 4'h5,
                           OP_SB  = 4'h9, OP_SH  = 4'hA, OP_SW = 4'hB;

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
`ifdef LSU_MISALIGN_CHECK_EN
    logic                  err_q, err_d;
    logic                  misal;
`endif

    logic                  in_is_load, in_is_store, q_is_load;
    logic [1:0]            off;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    assign off         = exu_res[1:0];
    assign in_is_load  = lsu_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    assign in_is_store = lsu_op inside {OP_SB, OP_SH, OP_SW};
    assign q_is_load   = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

`ifdef LSU_MISALIGN_CHECK_EN
    assign misal = ((lsu_op inside {OP_LH, OP_LHU, OP_SH}) && off[0]) ||
                   ((lsu_op inside {OP_LW, OP_SW}) && (off != 2'b00));
`endif

    // Lane selection uses the offset latched at accept; the bus address is word-aligned.
    assign rd_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    assign rd_half = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = bus.mem_rdata;
        case (op_q)
            OP_LB:   ld_ext = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            OP_LBU:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
            OP_LH:   ld_ext = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            OP_LHU:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, rd_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        res_d   = res_q;
`ifdef LSU_MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = lsu_op;
                off_d   = off;
                addr_d  = {exu_res[DATA_WIDTH-1:2], 2'b00};
                wen_d   = in_is_store;
                wdata_d = '0;
                wmask_d = '0;
                case (lsu_op)
                    OP_SB: begin
                        wdata_d = {MASK_WIDTH{data_Rs2[7:0]}};
                        wmask_d = MASK_WIDTH'(1) << off;
                    end
                    OP_SH: begin
                        wdata_d = {(MASK_WIDTH/2){data_Rs2[15:0]}};
                        wmask_d = MASK_WIDTH'(3) << {off[1], 1'b0};
                    end
                    OP_SW: begin
                        wdata_d = data_Rs2;
                        wmask_d = '1;
                    end
                    default: ;
                endcase
                if (!(in_is_load || in_is_store)) begin
                    res_d   = exu_res;
                    state_d = DONE;
`ifdef LSU_MISALIGN_CHECK_EN
                end else if (misal) begin
                    wen_d   = 1'b0;
                    wmask_d = '0;
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    state_d = REQ;
                end
            end
            REQ:  if (bus.mem_req_ready) state_d = WAIT;
            WAIT: if (bus.mem_resp_valid) begin
                res_d   = q_is_load ? ld_ext : '0;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            res_q   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            res_q   <= res_d;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == DONE);
    assign lsu_res           = res_q;
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_wen       = wen_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
`ifdef LSU_MISALIGN_CHECK_EN
    assign lsu_err           = err_q;
`endif
endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// Scoreboard bench for ysyx_23060191_lsu: expected requests/results queued at issue,
// popped by monitors on each bus-request and write-back handshake.
module tb_ysyx_23060191_lsu;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [3:0]  lsu_op = 0;
    logic [31:0] exu_res = 0, data_Rs2 = 0, lsu_res;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        lsu_err;
`endif

    ysyx_23060191_lsu_if #(.DATA_WIDTH(32), .MASK_WIDTH(4)) bus ();

    ysyx_23060191_lsu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lsu_op(lsu_op), .exu_res(exu_res), .data_Rs2(data_Rs2), .bus(bus),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef LSU_MISALIGN_CHECK_EN
        .lsu_err(lsu_err),
`endif
        .lsu_res(lsu_res)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_res[$];
    int          n_cmp = 0, n_err = 0;
    int          req_seen = 0;

    // responder controls
    int          stall_left = 0;
    logic        hold_resp = 0;
    int          pulse_req = 0;
    logic [31:0] rdata_v = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Memory responder: ready after stall_left cycles of a valid request, data the cycle after handshake.
    initial begin : responder
        logic hs_now;
        int   last_pulse;
        last_pulse = 0;
        bus.mem_req_ready  = 0;
        bus.mem_resp_valid = 0;
        bus.mem_rdata      = 0;
        forever begin
            @(posedge clk); #1;
            hs_now = bus.mem_req_ready;
            bus.mem_req_ready  = 0;
            bus.mem_resp_valid = 0;
            if (hs_now && !hold_resp) begin
                bus.mem_resp_valid = 1;
                bus.mem_rdata      = rdata_v;
            end
            if (pulse_req != last_pulse) begin
                last_pulse         = pulse_req;
                bus.mem_resp_valid = 1;
                bus.mem_rdata      = 32'hA5A5_A5A5;
            end
            if (bus.mem_req_valid && !hs_now) begin
                if (stall_left > 0) stall_left--;
                else bus.mem_req_ready = 1;
            end
        end
    end

    initial begin : req_monitor
        req_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
                req_seen++;
                if (exp_req.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    e = exp_req.pop_front();
                    chk("req_wen",   {31'b0, bus.mem_wen}, {31'b0, e.wen});
                    chk("req_addr",  bus.mem_addr, e.addr);
                    chk("req_wmask", {28'b0, bus.mem_wmask}, {28'b0, e.wmask});
                    if (e.wen) chk("req_wdata", bus.mem_wdata, e.wdata);
                end
            end
        end
    end

    initial begin : res_monitor
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_res.size() == 0) chk("unexpected_out", 1, 0);
                else chk("lsu_res", lsu_res, exp_res.pop_front());
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [31:0] rs2);
        chk("in_ready_idle", {31'b0, in_ready}, 1);
        in_valid = 1; lsu_op = op; exu_res = res; data_Rs2 = rs2;
        tick();
        in_valid = 0; lsu_op = 0; exu_res = 0; data_Rs2 = 0;
    endtask

    // returns latency in cycles from the accept edge to out_valid
    task automatic wait_out(output int lat);
        int n = 0;
        while (out_valid !== 1'b1 && n < 30) begin tick(); n++; end
        if (out_valid !== 1'b1) chk("wait_out_timeout", 0, 1);
        lat = n + 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 30) begin tick(); n++; end
        if (in_ready !== 1'b1) chk("wait_idle_timeout", 0, 1);
    endtask

    // load/store with immediate ready, one-cycle response, latency check
    task automatic mem_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                          input logic [31:0] rd, input req_t r, input logic [31:0] res);
        int lat;
        rdata_v = rd;
        exp_req.push_back(r);
        exp_res.push_back(res);
        issue(op, a, rs2);
        wait_out(lat);
        chk("mem_latency", lat, 3);
        wait_idle();
    endtask

    initial begin : main
        int lat, seen0, ov;
        repeat (3) tick();
        rst = 0;
        chk("rst_in_ready",  {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_req_valid", {31'b0, bus.mem_req_valid}, 0);
        chk("rst_wen",       {31'b0, bus.mem_wen}, 0);
        chk("rst_addr",      bus.mem_addr, 0);
        chk("rst_wdata",     bus.mem_wdata, 0);
        chk("rst_wmask",     {28'b0, bus.mem_wmask}, 0);
        chk("rst_lsu_res",   lsu_res, 0);

        // NONE passthrough, plus an undefined code treated as NONE
        seen0 = req_seen;
        exp_res.push_back(32'h1234_5678);
        issue(4'h0, 32'h1234_5678, 32'hFFFF_FFFF);
        wait_out(lat);
        chk("none_latency", lat, 1);
        wait_idle();
        exp_res.push_back(32'hCAFE_0003);
        issue(4'h7, 32'hCAFE_0003, 32'h0);
        wait_out(lat);
        chk("bad_op_latency", lat, 1);
        wait_idle();
        chk("none_no_req", req_seen, seen0);

        // loads: extraction and extension
        mem_op(4'h1, 32'h8000_0003, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0000, 32'h0, 4'b0000}, 32'hFFFF_FF80);
        mem_op(4'h4, 32'h8000_0003, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0000, 32'h0, 4'b0000}, 32'h0000_0080);
        mem_op(4'h1, 32'h8000_0000, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0000, 32'h0, 4'b0000}, 32'h0000_0011);
        mem_op(4'h2, 32'h8000_0012, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0010, 32'h0, 4'b0000}, 32'hFFFF_80FF);
        mem_op(4'h5, 32'h8000_0012, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0010, 32'h0, 4'b0000}, 32'h0000_80FF);
        mem_op(4'h3, 32'h8000_0020, 0, 32'h1357_9BDF, '{1'b0, 32'h8000_0020, 32'h0, 4'b0000}, 32'h1357_9BDF);

        // stores: lane masks and replicated data
        mem_op(4'hA, 32'h8000_0102, 32'hDEAD_BEEF, 0, '{1'b1, 32'h8000_0100, 32'hBEEF_BEEF, 4'b1100}, 32'h0);
        mem_op(4'h9, 32'h8000_0201, 32'h1234_5678, 0, '{1'b1, 32'h8000_0200, 32'h7878_7878, 4'b0010}, 32'h0);
        mem_op(4'h9, 32'h8000_0203, 32'h1234_56AB, 0, '{1'b1, 32'h8000_0200, 32'hABAB_ABAB, 4'b1000}, 32'h0);
        mem_op(4'hB, 32'h8000_0300, 32'hA1B2_C3D4, 0, '{1'b1, 32'h8000_0300, 32'hA1B2_C3D4, 4'b1111}, 32'h0);

`ifndef LSU_MISALIGN_CHECK_EN
        // misaligned without checking: half ignores off[0], word ignores offset
        mem_op(4'h2, 32'h8000_0003, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0000, 32'h0, 4'b0000}, 32'hFFFF_80FF);
        mem_op(4'h3, 32'h8000_0001, 0, 32'h80FF_0011, '{1'b0, 32'h8000_0000, 32'h0, 4'b0000}, 32'h80FF_0011);
`else
        seen0 = req_seen;
        exp_res.push_back(32'h0);
        issue(4'h3, 32'h8000_0001, 0);
        wait_out(lat);
        chk("mis_latency", lat, 1);
        chk("mis_err", {31'b0, lsu_err}, 1);
        chk("mis_req_valid", {31'b0, bus.mem_req_valid}, 0);
        wait_idle();
        chk("mis_err_clr", {31'b0, lsu_err}, 0);
        exp_res.push_back(32'h0);
        issue(4'hA, 32'h8000_0003, 32'h1111_2222);
        wait_out(lat);
        chk("mis_sh_err", {31'b0, lsu_err}, 1);
        wait_idle();
        chk("mis_no_req", req_seen, seen0);
`endif

        // LW with request stall and write-back back-pressure
        rdata_v = 32'h0BAD_F00D;
        stall_left = 3;
        out_ready = 0;
        exp_req.push_back('{1'b0, 32'h8000_0400, 32'h0, 4'b0000});
        exp_res.push_back(32'h0BAD_F00D);
        issue(4'h3, 32'h8000_0400, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", {31'b0, bus.mem_req_valid}, 1);
            chk("stall_addr", bus.mem_addr, 32'h8000_0400);
            chk("stall_wen", {31'b0, bus.mem_wen}, 0);
            chk("stall_in_ready", {31'b0, in_ready}, 0);
            tick();
        end
        wait_out(lat);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_lsu_res", lsu_res, 32'h0BAD_F00D);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
        end
        out_ready = 1;
        tick();
        chk("bp_released", {31'b0, out_valid}, 0);
        wait_idle();

        // reset while in WAIT, then a stray response
        hold_resp = 1;
        exp_req.push_back('{1'b0, 32'h8000_0500, 32'h0, 4'b0000});
        issue(4'h3, 32'h8000_0500, 0);
        tick();
        chk("wait_req_dropped", {31'b0, bus.mem_req_valid}, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("wrst_in_ready", {31'b0, in_ready}, 1);
        chk("wrst_outs", {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, out_valid}, 0);
        chk("wrst_addr", bus.mem_addr, 0);
        chk("wrst_wdata", bus.mem_wdata, 0);
        chk("wrst_lsu_res", lsu_res, 0);
        pulse_req++;
        ov = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid === 1'b1 || in_ready !== 1'b1) ov++;
        end
        chk("stray_resp_ignored", ov, 0);
        hold_resp = 0;

        // a normal op still works after the abandoned one
        mem_op(4'h5, 32'h8000_0600, 0, 32'h1234_ABCD, '{1'b0, 32'h8000_0600, 32'h0, 4'b0000}, 32'h0000_ABCD);

        repeat (3) tick();
        chk("req_queue_drained", exp_req.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
